rom_stream_reader: RTL and testbench

Sequencer that sits directly upstream of the synchronous single-port block ROM. It drives the ROM address, absorbs the ROM's one-cycle registered read latency, and presents the words as a valid/ready stream to downstream logic. A burst is started with a base address and word count. A 2-entry output buffer gives full throughput with back-pressure and never drops a word.

---
 rtl/rom_stream_reader.sv | 157 +++++++++++++++
 tb/tb_rom_stream_reader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_stream_reader.sv
// rom_stream_reader
// Sequencer placed in front of a synchronous single-port block ROM with a
// one-cycle registered read. A burst (base address + word count) is started
// from IDLE. Words are fetched one per cycle and delivered as a valid/ready
// stream through a 2-entry output buffer, so back-pressure never drops a word.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      burst request, sampled only in IDLE
//   base_addr_i  first ROM address of the burst (sampled with start_i)
//   length_i     burst word count, 0..2**memSize_p (sampled with start_i)
//   rom_addr_o   registered ROM address
//   rom_data_i   ROM read data, one cycle after the address is sampled
//   data_o       stream data (buffer head)
//   valid_o      stream valid (buffer not empty)
//   ready_i      stream ready from downstream
//   busy_o       high while a burst is running
//   done_o       one-cycle pulse after the last word of a burst is accepted
module rom_stream_reader #(
    parameter int memSize_p   = 8,
    parameter int dataWidth_p = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [memSize_p-1:0]   base_addr_i,
    input  logic [memSize_p:0]     length_i,
    output logic [memSize_p-1:0]   rom_addr_o,
    input  logic [dataWidth_p-1:0] rom_data_i,
    output logic [dataWidth_p-1:0] data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   busy_o,
    output logic                   done_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [memSize_p-1:0]   addr_q, addr_d;
    logic [memSize_p:0]     rem_q, rem_d;
    logic                   pend_q, pend_d;
    logic [1:0]             count_q, count_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   done_q, done_d;
    logic [dataWidth_p-1:0] mem0_q, mem1_q;

    logic                   pop_s;
    logic                   push_s;
    logic                   issue_s;
    logic [2:0]             occ_s;

    // Stream outputs come straight from the buffer and state registers.
    always_comb begin
        data_o     = rd_ptr_q ? mem1_q : mem0_q;
        valid_o    = (count_q != 2'd0);
        busy_o     = (state_q == RUN);
        done_o     = done_q;
        rom_addr_o = addr_q;
    end

    // Next-state logic: read issue, buffer bookkeeping and the IDLE/RUN FSM.
    always_comb begin
        pop_s  = (count_q != 2'd0) & ready_i;
        push_s = pend_q;
        // Occupancy after this edge if no new read is issued; a pop implies
        // count_q >= 1, so the subtraction never underflows.
        occ_s   = {1'b0, count_q} + {2'b00, pend_q} - {2'b00, pop_s};
        issue_s = (state_q == RUN) && (rem_q != {(memSize_p+1){1'b0}}) && (occ_s < 3'd2);

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        rd_ptr_d = pop_s  ? ~rd_ptr_q : rd_ptr_q;
        wr_ptr_d = push_s ? ~wr_ptr_q : wr_ptr_q;

        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        pend_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    addr_d  = base_addr_i;
                    rem_d   = length_i;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                pend_d = issue_s;
                if (issue_s) begin
                    addr_d = addr_q + {{(memSize_p-1){1'b0}}, 1'b1};
                    rem_d  = rem_q - {{memSize_p{1'b0}}, 1'b1};
                end else begin
                    addr_d = addr_q;
                end
                // Finish on the edge that drains the last word (or at once
                // for an empty burst): nothing left to issue, nothing in flight.
                if ((rem_q == {(memSize_p+1){1'b0}}) && !pend_q && (count_d == 2'd0)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers and buffer storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            addr_q   <= {memSize_p{1'b0}};
            rem_q    <= {(memSize_p+1){1'b0}};
            pend_q   <= 1'b0;
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            done_q   <= 1'b0;
            mem0_q   <= {dataWidth_p{1'b0}};
            mem1_q   <= {dataWidth_p{1'b0}};
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            pend_q   <= pend_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            done_q   <= done_d;
            if (push_s) begin
                if (wr_ptr_q) begin
                    mem1_q <= rom_data_i;
                end else begin
                    mem0_q <= rom_data_i;
                end
            end else begin
                mem0_q <= mem0_q;
                mem1_q <= mem1_q;
            end
        end
    end

endmodule

// File: tb/tb_rom_stream_reader.sv
module tb_rom_stream_reader;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  base_addr_i = 8'h00;
    logic [8:0]  length_i = 9'd0;
    logic [7:0]  rom_addr_o;
    logic [15:0] rom_data_i;
    logic [15:0] data_o;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic        busy_o;
    logic        done_o;

    logic [15:0] rom_mem [256];
    int          ready_mode = 0;

    int          total = 0;
    int          bad = 0;

    logic [15:0] exp_q [$];
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_left = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = 16'h0000;

    rom_stream_reader #(.memSize_p(8), .dataWidth_p(16)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .length_i    (length_i),
        .rom_addr_o  (rom_addr_o),
        .rom_data_i  (rom_data_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    // Synchronous ROM model with one-cycle registered read.
    always_ff @(posedge clk) rom_data_i <= rom_mem[rom_addr_o];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Downstream ready pattern.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       ready_i = 1'b1;
                1:       ready_i = 1'($urandom_range(0, 1));
                default: ready_i = 1'b0;
            endcase
        end
    end

    // Monitor + behavioural burst model: checks current outputs, then advances
    // the model to what the next edge should produce.
    initial begin
        logic hs;
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                prev_stall = 1'b0;
            end else begin
                chk("busy", 32'(busy_o), 32'(m_busy));
                chk("done", 32'(done_o), 32'(m_done));
                chk("count_le_2", 32'(dut.count_q <= 2'd2), 32'd1);
                if (prev_stall) begin
                    chk("stall_valid", 32'(valid_o), 32'd1);
                    chk("stall_data", 32'(data_o), 32'(prev_data));
                end
                hs = valid_o & ready_i;
                if (hs) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_word", 32'(data_o), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data", 32'(data_o), 32'(e));
                    end
                end
                prev_stall = valid_o & ~ready_i;
                prev_data  = data_o;
                m_done = 1'b0;
                if (!m_busy) begin
                    if (start_i) begin
                        m_busy = 1'b1;
                        m_left = int'(length_i);
                        for (int i = 0; i < int'(length_i); i++)
                            exp_q.push_back(16'h0100 + 16'((int'(base_addr_i) + i) % 256));
                    end
                end else begin
                    if (hs) m_left--;
                    if (m_left <= 0) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end
        end
    end

    // Issues a start and returns one time unit after the sampling edge.
    task automatic start_burst(input logic [7:0] b, input logic [8:0] l);
        @(posedge clk);
        #1;
        start_i = 1'b1;
        base_addr_i = b;
        length_i = l;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        base_addr_i = $urandom_range(0, 255);
        length_i = 9'($urandom_range(0, 256));
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (n < budget && !(busy_o == 1'b0 && exp_q.size() == 0)) begin
            @(negedge clk);
            n++;
        end
        chk("burst_complete", 32'(n < budget), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'h0100 + 16'(i);

        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_addr", 32'(rom_addr_o), 32'd0);
        rst_ni = 1'b1;

        // Basic burst with latency check.
        ready_mode = 0;
        start_burst(8'h10, 9'd4);
        chk("t1_busy", 32'(busy_o), 32'd1);
        chk("t1_addr", 32'(rom_addr_o), 32'h10);
        @(negedge clk);
        chk("t1_valid_e0", 32'(valid_o), 32'd0);
        @(negedge clk);
        chk("t1_valid_e1", 32'(valid_o), 32'd0);
        @(negedge clk);
        chk("t1_valid_e2", 32'(valid_o), 32'd1);
        chk("t1_first", 32'(data_o), 32'h110);
        wait_idle(50);

        // Wrap across the top of the ROM.
        start_burst(8'hFE, 9'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_addr", 32'(rom_addr_o), 32'((8'hFE + i) % 256));
            @(posedge clk);
            #1;
        end
        wait_idle(50);

        // Random back-pressure.
        ready_mode = 1;
        start_burst(8'h40, 9'd6);
        wait_idle(200);

        // Empty burst.
        ready_mode = 0;
        start_burst(8'h55, 9'd0);
        wait_idle(20);

        // Start while running is ignored.
        ready_mode = 1;
        start_burst(8'h70, 9'd6);
        @(posedge clk);
        #1;
        start_i = 1'b1;
        base_addr_i = 8'h99;
        length_i = 9'd3;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_idle(200);

        // Random bursts.
        for (int k = 0; k < 12; k++) begin
            start_burst(8'($urandom_range(0, 255)), 9'($urandom_range(0, 8)));
            wait_idle(200);
        end

        // Full-ROM burst.
        start_burst(8'($urandom_range(0, 255)), 9'd256);
        wait_idle(3000);

        // Asynchronous reset mid-burst with the buffer full.
        ready_mode = 2;
        start_burst(8'h30, 9'd6);
        repeat (6) @(posedge clk);
        #2;
        chk("t6_full", 32'(dut.count_q), 32'd2);
        rst_ni = 1'b0;
        #1;
        chk("t6_valid", 32'(valid_o), 32'd0);
        chk("t6_busy", 32'(busy_o), 32'd0);
        chk("t6_done", 32'(done_o), 32'd0);
        chk("t6_data", 32'(data_o), 32'd0);
        chk("t6_addr", 32'(rom_addr_o), 32'd0);
        exp_q.delete();
        m_busy = 1'b0;
        m_done = 1'b0;
        m_left = 0;
        @(posedge clk);
        #2;
        rst_ni = 1'b1;
        ready_mode = 0;
        start_burst(8'h20, 9'd2);
        wait_idle(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
